// File: rtl/scsp_dma_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scsp_dma_ctrl_pkg : shared widths, DMA state encoding and IRQ bit index
// Rev 1.0
// ----------------------------------------------------------------------------
package scsp_dma_ctrl_pkg;

  localparam int RAM_AW       = 19;
  localparam int REG_AW       = 11;
  localparam int DATA_W       = 16;
  localparam int CNT_W        = 11;
  // SCIPD/MCIPD bit raised by the DMA-end source
  localparam int SCSP_IRQ_DMA = 4;

  typedef enum logic [1:0] {
    DST_IDLE  = 2'd0,
    DST_READ  = 2'd1,
    DST_WRITE = 2'd2,
    DST_DONE  = 2'd3
  } DMAState_t;

endpackage
`default_nettype wire

// File: rtl/scsp_dma_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scsp_dma_ctrl_if : sound-RAM and register-space request/ready buses
// Rev 1.0
// ----------------------------------------------------------------------------
interface scsp_dma_ctrl_if;
  import scsp_dma_ctrl_pkg::*;

  logic [RAM_AW-1:0] RAM_A;
  logic [DATA_W-1:0] RAM_D;
  logic [DATA_W-1:0] RAM_Q;
  logic              RAM_RD;
  logic              RAM_WE;
  logic              RAM_RDY;

  logic [REG_AW-1:0] REG_A;
  logic [DATA_W-1:0] REG_D;
  logic [DATA_W-1:0] REG_Q;
  logic              REG_RD;
  logic              REG_WE;
  logic              REG_RDY;

  modport master (
    output RAM_A, RAM_D, RAM_RD, RAM_WE,
    output REG_A, REG_D, REG_RD, REG_WE,
    input  RAM_Q, RAM_RDY, REG_Q, REG_RDY
  );

  modport slave (
    input  RAM_A, RAM_D, RAM_RD, RAM_WE,
    input  REG_A, REG_D, REG_RD, REG_WE,
    output RAM_Q, RAM_RDY, REG_Q, REG_RDY
  );

endinterface
`default_nettype wire

// File: rtl/scsp_dma_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scsp_dma_ctrl : SCSP sound-RAM <-> register-space DMA sequencer
// Rev 1.0 | optional DMA_ABORT port enabled by SCSP_DMA_ABORT_EN
// ----------------------------------------------------------------------------
module scsp_dma_ctrl
  import scsp_dma_ctrl_pkg::*;
(
  input  wire logic              CLK,
  input  wire logic              RST_N,
  input  wire logic              CE,
  input  wire logic [RAM_AW-1:0] DMEA,
  input  wire logic [REG_AW-1:0] DRGA,
  input  wire logic [CNT_W-1:0]  DTLG,
  input  wire logic              DDIR,
  input  wire logic              DGATE,
  input  wire logic              DEXE_SET,
  output logic                   BUSY,
  output logic                   DONE_IRQ,
`ifdef SCSP_DMA_ABORT_EN
  input  wire logic              DMA_ABORT,
`endif
  scsp_dma_ctrl_if.master        bus
);

  DMAState_t         state_q;
  logic [RAM_AW-1:0] ram_a_q;
  logic [REG_AW-1:0] reg_a_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              dir_q;
  logic              gate_q;
  logic              zero_q;
  logic              busy_q;
  logic              irq_q;
  logic              ram_rd_q, ram_we_q, reg_rd_q, reg_we_q;

  logic              src_rdy;
  logic              dst_rdy;
  logic [DATA_W-1:0] src_q;
  logic              abort_req;

  // DDIR=0 reads RAM and writes registers; DDIR=1 the reverse
  assign src_rdy = dir_q ? bus.REG_RDY : bus.RAM_RDY;
  assign dst_rdy = dir_q ? bus.RAM_RDY : bus.REG_RDY;
  assign src_q   = dir_q ? bus.REG_Q   : bus.RAM_Q;

`ifdef SCSP_DMA_ABORT_EN
  logic abort_q;
  assign abort_req = DMA_ABORT | abort_q;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= DST_IDLE;
      ram_a_q  <= '0;
      reg_a_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      dir_q    <= 1'b0;
      gate_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
      ram_rd_q <= 1'b0;
      ram_we_q <= 1'b0;
      reg_rd_q <= 1'b0;
      reg_we_q <= 1'b0;
`ifdef SCSP_DMA_ABORT_EN
      abort_q  <= 1'b0;
`endif
    end else if (CE) begin
      irq_q <= 1'b0;
`ifdef SCSP_DMA_ABORT_EN
      // An abort is held until the outstanding access has been acknowledged
      if (state_q == DST_IDLE)
        abort_q <= 1'b0;
      else if (DMA_ABORT && state_q != DST_DONE)
        abort_q <= 1'b1;
`endif
      unique case (state_q)
        DST_IDLE: begin
          if (DEXE_SET) begin
            ram_a_q <= DMEA;
            reg_a_q <= DRGA;
            cnt_q   <= DTLG;
            dir_q   <= DDIR;
            gate_q  <= DGATE;
            data_q  <= '0;
            busy_q  <= 1'b1;
            if (DTLG == '0) begin
              state_q <= DST_DONE;
              zero_q  <= 1'b1;
            end else if (DGATE) begin
              state_q  <= DST_WRITE;
              ram_we_q <= DDIR;
              reg_we_q <= ~DDIR;
            end else begin
              state_q  <= DST_READ;
              ram_rd_q <= ~DDIR;
              reg_rd_q <= DDIR;
            end
          end
        end

        DST_READ: begin
          if (src_rdy) begin
            data_q   <= src_q;
            ram_rd_q <= 1'b0;
            reg_rd_q <= 1'b0;
            if (abort_req) begin
              state_q <= DST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= DST_WRITE;
              ram_we_q <= dir_q;
              reg_we_q <= ~dir_q;
            end
          end
        end

        DST_WRITE: begin
          if (dst_rdy) begin
            ram_a_q  <= ram_a_q + RAM_AW'(1);
            reg_a_q  <= reg_a_q + REG_AW'(1);
            cnt_q    <= cnt_q - CNT_W'(1);
            ram_we_q <= 1'b0;
            reg_we_q <= 1'b0;
            if (abort_req) begin
              state_q <= DST_IDLE;
              busy_q  <= 1'b0;
            end else if (cnt_q == CNT_W'(1)) begin
              state_q <= DST_DONE;
            end else if (gate_q) begin
              ram_we_q <= dir_q;
              reg_we_q <= ~dir_q;
            end else begin
              state_q  <= DST_READ;
              ram_rd_q <= ~dir_q;
              reg_rd_q <= dir_q;
            end
          end
        end

        DST_DONE: begin
          // A zero-length transfer lingers one extra cycle so BUSY is seen for two
          if (zero_q) begin
            zero_q <= 1'b0;
          end else begin
            state_q <= DST_IDLE;
            busy_q  <= 1'b0;
            irq_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign BUSY       = busy_q;
  assign DONE_IRQ   = irq_q;
  assign bus.RAM_A  = ram_a_q;
  assign bus.RAM_D  = data_q;
  assign bus.RAM_RD = ram_rd_q;
  assign bus.RAM_WE = ram_we_q;
  assign bus.REG_A  = reg_a_q;
  assign bus.REG_D  = data_q;
  assign bus.REG_RD = reg_rd_q;
  assign bus.REG_WE = reg_we_q;

endmodule
`default_nettype wire

// File: tb/tb_scsp_dma_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_scsp_dma_ctrl : randomized bench for scsp_dma_ctrl against a transfer model
// Rev 1.0 | define SCSP_DMA_ABORT_EN to exercise the abort port
// ----------------------------------------------------------------------------
module tb_scsp_dma_ctrl;

  localparam int LIMIT = 5000;

  logic        CLK, RST_N, CE, DDIR, DGATE, DEXE_SET, BUSY, DONE_IRQ;
  logic [18:0] DMEA;
  logic [10:0] DRGA, DTLG;
`ifdef SCSP_DMA_ABORT_EN
  logic        DMA_ABORT;
`endif

  scsp_dma_ctrl_if bus();

  scsp_dma_ctrl dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE       (CE),
    .DMEA     (DMEA),
    .DRGA     (DRGA),
    .DTLG     (DTLG),
    .DDIR     (DDIR),
    .DGATE    (DGATE),
    .DEXE_SET (DEXE_SET),
    .BUSY     (BUSY),
    .DONE_IRQ (DONE_IRQ),
`ifdef SCSP_DMA_ABORT_EN
    .DMA_ABORT(DMA_ABORT),
`endif
    .bus      (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          seed;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          wait_tab[$];
  int          req_idx, wait_left, hold_cnt, first_hold;
  bit          req_active, launch, noise_en;
  logic [63:0] hold_sig;
  int          busy_cnt, irq_cnt, onehot_err, stable_err, ce_pct, abort_at;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ram_val(input int a);
    return 16'((a * 40503) ^ (a >> 5) ^ seed);
  endfunction

  function automatic logic [15:0] reg_val(input int a);
    return 16'((a * 27361) ^ 16'h5A3C ^ (seed >> 8));
  endfunction

  // kind: 0 RAM read, 1 RAM write, 2 REG read, 3 REG write
  function automatic logic [63:0] pack(input int kind, input int addr, input int data);
    return {8'(kind), 32'(addr), 8'h00, 16'(data)};
  endfunction

  // One CE-qualified cycle: observe outputs at negedge, then act as both memories
  task automatic tick();
    int nreq, kind, a, d;
    bit rdy, abt;
    @(negedge CLK);
    nreq = int'(bus.RAM_RD) + int'(bus.RAM_WE) + int'(bus.REG_RD) + int'(bus.REG_WE);
    if (nreq > 1) onehot_err++;
    kind = bus.RAM_RD ? 0 : bus.RAM_WE ? 1 : bus.REG_RD ? 2 : 3;
    a    = (kind < 2) ? int'(bus.RAM_A) : int'(bus.REG_A);
    d    = (kind == 1) ? int'(bus.RAM_D) : (kind == 3) ? int'(bus.REG_D) : 0;
    abt  = (abort_at >= 0 && nreq > 0 && req_idx == abort_at);
    CE   = launch ? 1'b1 : (int'($urandom_range(99)) < ce_pct);
    DEXE_SET = launch || (noise_en && BUSY && $urandom_range(2) == 0);
    if (noise_en && !launch) begin
      DMEA  = 19'($urandom);
      DRGA  = 11'($urandom);
      DTLG  = 11'($urandom);
      DDIR  = 1'($urandom);
      DGATE = 1'($urandom);
    end
    rdy = 1'b0;
    if (nreq > 0) begin
      if (!req_active) begin
        req_active = 1'b1;
        hold_sig   = pack(kind, a, d);
        hold_cnt   = 0;
        wait_left  = (req_idx < wait_tab.size()) ? wait_tab[req_idx] : 0;
      end else if (pack(kind, a, d) != hold_sig) begin
        stable_err++;
      end
      rdy = (wait_left == 0);
      if (CE) begin
        hold_cnt++;
        if (rdy) begin
          obs_q.push_back(pack(kind, a, d));
          if (req_idx == 0) first_hold = hold_cnt;
          req_idx++;
          req_active = 1'b0;
        end else begin
          wait_left--;
        end
      end
    end else if (req_active) begin
      stable_err++;
      req_active = 1'b0;
    end
    bus.RAM_RDY = (nreq > 0 && kind < 2)  ? rdy : 1'($urandom_range(1));
    bus.REG_RDY = (nreq > 0 && kind >= 2) ? rdy : 1'($urandom_range(1));
    bus.RAM_Q   = (nreq > 0 && kind == 0 && rdy) ? ram_val(a) : 16'($urandom);
    bus.REG_Q   = (nreq > 0 && kind == 2 && rdy) ? reg_val(a) : 16'($urandom);
`ifdef SCSP_DMA_ABORT_EN
    DMA_ABORT = abt;
`else
    if (abt) abort_at = -1;
`endif
    if (CE) begin
      busy_cnt += int'(BUSY);
      irq_cnt  += int'(DONE_IRQ);
    end
    launch = 1'b0;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    req_idx = 0; req_active = 1'b0; first_hold = 0;
    busy_cnt = 0; irq_cnt = 0; onehot_err = 0; stable_err = 0;
  endtask

  task automatic run_xfer(input string tag, input logic [18:0] dmea, input logic [10:0] drga,
                          input logic [10:0] len, input bit dir, input bit gate,
                          input int wmode, input int cep, input int abt);
    int wsum, exp_busy, n, ra, ga, v;
    exp_q.delete(); wait_tab.delete();
    for (int i = 0; i < int'(len); i++) begin
      ra = (int'(dmea) + i) % (1 << 19);
      ga = (int'(drga) + i) % (1 << 11);
      if (gate) begin
        v = 0;
      end else begin
        v = dir ? int'(reg_val(ga)) : int'(ram_val(ra));
        exp_q.push_back(pack(dir ? 2 : 0, dir ? ga : ra, 0));
      end
      exp_q.push_back(pack(dir ? 1 : 3, dir ? ra : ga, v));
    end
    if (abt >= 0 && abt < exp_q.size()) exp_q = exp_q[0:abt];
    wsum = 0;
    foreach (exp_q[i]) begin
      wait_tab.push_back(wmode == 1 ? int'($urandom_range(3)) : (wmode == 2 && i == 0) ? 5 : 0);
      wsum += wait_tab[i];
    end
    exp_busy = (len == 0) ? 2 : exp_q.size() + wsum + ((abt >= 0) ? 0 : 1);
    clear_obs();
    DMEA = dmea; DRGA = drga; DTLG = len; DDIR = dir; DGATE = gate;
    ce_pct = cep; abort_at = abt; launch = 1'b1;
    tick();
    n = 0;
    do begin
      tick();
      n++;
    end while (BUSY === 1'b1 && n < LIMIT);
    check_eq({tag, "_tmo"}, 64'(n < LIMIT), 64'd1);
    check_eq({tag, "_irq_at_fall"}, 64'(DONE_IRQ), (abt >= 0) ? 64'd0 : 64'd1);
    repeat (4) tick();
    check_eq({tag, "_busy_cyc"}, 64'(busy_cnt), 64'(exp_busy));
    check_eq({tag, "_irq_cnt"}, 64'(irq_cnt), (abt >= 0) ? 64'd0 : 64'd1);
    check_eq({tag, "_ntxn"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq($sformatf("%s_txn%0d", tag, i), obs_q[i], exp_q[i]);
    check_eq({tag, "_proto"}, 64'(onehot_err + stable_err), 64'd0);
    abort_at = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; CE = 1'b0; DEXE_SET = 1'b0; DMEA = '0; DRGA = '0; DTLG = '0;
    DDIR = 1'b0; DGATE = 1'b0; noise_en = 1'b0; launch = 1'b0; abort_at = -1; ce_pct = 100;
    bus.RAM_Q = '0; bus.RAM_RDY = 1'b0; bus.REG_Q = '0; bus.REG_RDY = 1'b0;
`ifdef SCSP_DMA_ABORT_EN
    DMA_ABORT = 1'b0;
`endif
    seed = int'($urandom);
    clear_obs();
    repeat (3) @(negedge CLK);
    check_eq("rst_ctl", 64'({BUSY, DONE_IRQ, bus.RAM_RD, bus.RAM_WE, bus.REG_RD, bus.REG_WE,
                              bus.RAM_A, bus.REG_A}), 64'd0);
    check_eq("rst_data", 64'({bus.RAM_D, bus.REG_D}), 64'd0);
    RST_N = 1'b1;

    run_xfer("copy4",   19'h01000, 11'h300, 11'd4, 1'b0, 1'b0, 0, 100, -1);
    run_xfer("gate3",   19'h7FFFE, 11'h123, 11'd3, 1'b1, 1'b1, 0, 100, -1);
    run_xfer("wait5",   19'h00200, 11'h010, 11'd3, 1'b0, 1'b0, 2, 100, -1);
    check_eq("wait5_hold", 64'(first_hold), 64'd6);
    run_xfer("zero",    19'h12345, 11'h456, 11'd0, 1'b0, 1'b0, 0, 100, -1);
    run_xfer("rd_reg",  19'h3FFF0, 11'h7FE, 11'd5, 1'b1, 1'b0, 1, 100, -1);
    noise_en = 1'b1;
    run_xfer("noise",   19'h05000, 11'h100, 11'd6, 1'b0, 1'b0, 0, 100, -1);
    for (int k = 0; k < 10; k++)
      run_xfer($sformatf("rnd%0d", k),
               (k % 3 == 0) ? 19'h7FFF8 + 19'($urandom_range(7)) : 19'($urandom),
               (k % 4 == 1) ? 11'h7FC : 11'($urandom),
               11'($urandom_range(12)), 1'($urandom), 1'($urandom), 1, 70, -1);
    noise_en = 1'b0;

`ifdef SCSP_DMA_ABORT_EN
    run_xfer("abort",   19'h00400, 11'h040, 11'd8, 1'b0, 1'b0, 0, 100, 2);
`endif

    // Reset in the middle of a long copy
    clear_obs(); wait_tab.delete();
    DMEA = 19'h00800; DRGA = 11'h200; DTLG = 11'd20; DDIR = 1'b0; DGATE = 1'b0;
    ce_pct = 100; launch = 1'b1;
    tick();
    repeat (6) tick();
    check_eq("mid_busy", 64'(BUSY), 64'd1);
    #3 RST_N = 1'b0;
    #1;
    check_eq("mid_rst_ctl", 64'({BUSY, DONE_IRQ, bus.RAM_RD, bus.RAM_WE, bus.REG_RD, bus.REG_WE,
                                  bus.RAM_A, bus.REG_A}), 64'd0);
    check_eq("mid_rst_data", 64'({bus.RAM_D, bus.REG_D}), 64'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    clear_obs();
    repeat (20) tick();
    check_eq("post_rst_txn", 64'(obs_q.size()), 64'd0);
    check_eq("post_rst_irq", 64'(irq_cnt), 64'd0);
    check_eq("post_rst_busy", 64'(busy_cnt), 64'd0);

    run_xfer("after_rst", 19'h00010, 11'h020, 11'd3, 1'b0, 1'b0, 1, 80, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
